// File: rtl/countdown_timer.sv
// MM:SS packed-BCD countdown timer with button sync, 1 Hz prescaler
// and run/pause/done control, feeding the 4-digit display driver.
module countdown_timer #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned DIV_WIDTH   = 26,
  parameter logic [15:0] DEFAULT_VAL = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_btn_start,
  input  logic        i_btn_clear,
  input  logic        i_btn_load,
  input  logic [15:0] i_load_val,
  output logic [15:0] o_data,
  output logic        o_running,
  output logic        o_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  localparam logic [DIV_WIDTH-1:0] CNT_MAX =
    DIV_WIDTH'(TICK_DIV - 1);

  state_e               state_q, state_d;
  logic [15:0]          value_q, value_d;
  logic [15:0]          reload_q, reload_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           sync1_q, sync2_q, prev_q;
  logic [2:0]           ev;
  logic                 start_ev, clear_ev, load_ev;
  logic                 tick;
  logic [15:0]          dec_val;

  function automatic logic [15:0] clamp_bcd(
    input logic [15:0] v
  );
    logic [15:0] r;
    r = v;
    if (r[3:0] > 4'd9)   r[3:0]   = 4'd9;
    if (r[7:4] > 4'd5)   r[7:4]   = 4'd5;
    if (r[11:8] > 4'd9)  r[11:8]  = 4'd9;
    if (r[15:12] > 4'd9) r[15:12] = 4'd9;
    return r;
  endfunction

  function automatic logic [15:0] dec_bcd(
    input logic [15:0] v
  );
    logic [3:0] d0, d1, d2, d3;
    logic       b;
    {d3, d2, d1, d0} = v;
    b = 1'b0;
    if (d0 == 4'd0) begin
      d0 = 4'd9;
      b  = 1'b1;
    end else begin
      d0 = d0 - 4'd1;
    end
    if (b) begin
      if (d1 == 4'd0) begin
        d1 = 4'd5;
      end else begin
        d1 = d1 - 4'd1;
        b  = 1'b0;
      end
    end
    if (b) begin
      if (d2 == 4'd0) begin
        d2 = 4'd9;
      end else begin
        d2 = d2 - 4'd1;
        b  = 1'b0;
      end
    end
    if (b) d3 = d3 - 4'd1;
    return {d3, d2, d1, d0};
  endfunction

  // bit 0 start, bit 1 clear, bit 2 load
  assign ev       = sync2_q & ~prev_q;
  assign start_ev = ev[0];
  assign clear_ev = ev[1];
  assign load_ev  = ev[2];

  assign tick    = (state_q == RUN) && (cnt_q == CNT_MAX);
  assign dec_val = dec_bcd(value_q);

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    if (clear_ev) begin
      state_d = IDLE;
      value_d = reload_q;
      cnt_d   = '0;
    end else if (load_ev && state_q != RUN) begin
      state_d  = IDLE;
      value_d  = clamp_bcd(i_load_val);
      reload_d = clamp_bcd(i_load_val);
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ev && value_q != 16'h0000) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (start_ev) begin
            state_d = PAUSE;
            cnt_d   = tick ? '0 : cnt_q;
          end else if (tick) begin
            value_d = dec_val;
            cnt_d   = '0;
            if (dec_val == 16'h0000) state_d = DONE;
          end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
          end
        end
        PAUSE: begin
          if (start_ev) state_d = RUN;
        end
        DONE: begin
          if (start_ev) begin
            state_d = IDLE;
            value_d = reload_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      value_q  <= DEFAULT_VAL;
      reload_q <= DEFAULT_VAL;
      cnt_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      sync1_q  <= {i_btn_load, i_btn_clear, i_btn_start};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

  assign o_data    = value_q;
  assign o_running = (state_q == RUN);
  assign o_done    = (state_q == DONE);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- MM:SS countdown timer that produces the 16-bit packed-BCD word consumed by the 4-digit hex display driver. Layout is {min_tens, min_units, sec_tens, sec_units}, so the display shows the digits directly.
- Handles button synchronisation and edge detection, a 1 Hz prescaler, BCD borrow-chain decrement, and a run/pause/done state machine.
- Sits between the board buttons/switches and the display driver.

Parameters:
TICK_DIV, 50_000_000, clock cycles per one-second tick (must be >= 2)
DIV_WIDTH, 26, prescaler counter width; must hold TICK_DIV-1
DEFAULT_VAL, 16'h0100, BCD value loaded at reset (01:00)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
i_btn_start  input  1  start/pause button, asynchronous level
i_btn_clear  input  1  clear button, asynchronous level
i_btn_load  input  1  load button, asynchronous level
i_load_val  input  16  BCD preset from switches, sampled on load event
o_data  output  16  current BCD value, to display i_data
o_running  output  1  high in RUN
o_done  output  1  high in DONE

Behaviour:
- Clock/reset (already decided): one clock, clk. Reset rst is synchronous and active-high. Every register is updated only on posedge clk.
- Reset values: state IDLE, value = reload = DEFAULT_VAL, prescaler 0, all synchroniser/edge flops 0. Outputs: o_data = DEFAULT_VAL, o_running = 0, o_done = 0.
- Button path:
  - Each button goes through a 2-flop synchroniser, then a previous-value flop. Event = sync2 & ~prev, one cycle wide.
  - An input rising before edge N has its effect visible on the outputs after edge N+2.
  - A held button produces exactly one event.
- Load clamping: each loaded digit >9 is clamped to 9, and sec_tens >5 is clamped to 5. The clamped value is written to both reload and value.
- Event priority in the same cycle: clear > load > start.
- States and transitions:
  - IDLE: start with value != 0000 -> RUN, prescaler cleared to 0. Start with value == 0000 is ignored.
  - RUN: start -> PAUSE, prescaler held. Tick -> decrement; if the result is 0000 -> DONE.
  - PAUSE: start -> RUN, prescaler resumes from its held count.
  - DONE: value stays 0000. Start -> IDLE with value = reload.
  - Any state: clear -> IDLE, value = reload, prescaler 0.
  - Load is accepted in IDLE, PAUSE and DONE -> IDLE, value = reload = clamped i_load_val, prescaler 0. Load in RUN is ignored.
- Prescaler:
  - Counts only in RUN, from 0 to TICK_DIV-1, then wraps to 0.
  - tick = RUN & (cnt == TICK_DIV-1).
  - The first decrement occurs TICK_DIV cycles after entering RUN from IDLE.
  - A tick and a start event in the same cycle: start wins, with no decrement and a transition to PAUSE. The prescaler wraps to 0.
- BCD decrement (borrow chain):
  - sec_units 0 -> 9 with borrow, else -1.
  - sec_tens 0 -> 5 with borrow.
  - min_units 0 -> 9 with borrow.
  - min_tens -1 only on borrow.
  - 00:00 is never decremented; the DONE transition prevents wrap.
  - 99:59 is the maximum; there is no upward wrap path.
- Outputs: o_data = value register, combinationally taken from registers with no extra latency. o_running = (state == RUN). o_done = (state == DONE).
- Reset mid-run: the next edge forces the full reset state regardless of pending events or tick.

Test Plan:
- Reset (TICK_DIV=4): assert rst for 2 cycles -> o_data=16'h0100, o_running=0, o_done=0. Pulse start -> o_running=1 at edge+3. After 4 cycles o_data=16'h0059, after 4 more 16'h0058.
- Borrow chain: load 16'h1000, start, one tick -> 16'h0959. Load 16'h0010, start, one tick -> 16'h0009.
- Expiry: load 16'h0002, start -> after 2 ticks o_data=16'h0000, o_done=1, o_running=0. Further cycles leave o_data unchanged. Start -> IDLE, o_data=16'h0002.
- Pause/resume: start, wait 2 of 4 prescaler cycles, start -> PAUSE, o_data frozen for 20 cycles. Start -> the next decrement occurs exactly 2 cycles after resume.
- Load clamp and ignore: load 16'hAB7C in IDLE -> o_data=16'h9959. Load 16'h0030 during RUN -> ignored, countdown continues.
- Priority/glitch: clear and load rising in the same cycle -> clear wins, value = previous reload. Hold start high for 50 cycles -> exactly one RUN entry. Assert rst mid-RUN -> o_data=16'h0100 on the next edge.
